pc_stack_unit: RTL
==================

Name: pc_stack_unit

Overview:
- Parametrised next-generation program counter for the LC3 datapath.
- Holds the PC and selects its next value from four sources: PC+1, bus, address adder, or the saved-return stack.
- Adds an internal LIFO of saved PCs for trap/interrupt/subroutine return, with overflow and underflow tracking.
- Sits between the control store (load, mux, push and pop controls) and the datapath (bus, address adder, vector).

Parameters:
- WIDTH, 16, PC and data width in bits.
- RESET_VEC, 16'h3000, PC value loaded on reset (WIDTH bits).
- DEPTH, 4, number of return-stack entries; must be at least 1.
- DW, $clog2(DEPTH+1), width of o_Depth (derived; do not override).

Ports:
- i_CLK  in  1  clock, rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_LD_PC  in  1  load PC this edge.
- i_PCMUX  in  2  next-PC select: 00 PC+1, 01 i_Bus, 10 i_Addr, 11 stack top.
- i_Bus  in  WIDTH  global bus value.
- i_Addr  in  WIDTH  address-adder output.
- i_Push  in  1  push current PC (pre-update value) onto stack.
- i_Pop  in  1  pop stack top.
- i_ClrErr  in  1  clear sticky error flags.
- o_PC  out  WIDTH  current PC, to bus and ADDR1MUX.
- o_Top  out  WIDTH  stack top; 0 when empty.
- o_Depth  out  DW  number of valid entries.
- o_Full  out  1  o_Depth == DEPTH.
- o_Empty  out  1  o_Depth == 0.
- o_Overflow  out  1  sticky: push attempted while full.
- o_Underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset is asynchronous, active-high, on i_Reset; clock is i_CLK. While reset is asserted:
  - o_PC = RESET_VEC;
  - depth = 0, stack contents = 0;
  - o_Overflow = o_Underflow = 0.
  - Reset mid-operation discards pending push/pop. No other asynchronous behaviour.
- PC register:
  - On a rising edge with i_LD_PC=1, o_PC <= mux output; otherwise it holds.
  - PC+1 wraps modulo 2^WIDTH (all-ones + 1 = 0).
  - Mux is combinational; the new PC is visible on o_PC one cycle after the load edge.
- Mux 11 uses the o_Top value before the edge. If the stack is empty, the PC loads 0; underflow is flagged only if i_Pop is also asserted.
- Stack updates are evaluated on the same edge as the PC load, using pre-edge values:
  - Push only, not full: entry[depth] <= o_PC (pre-update); depth+1.
  - Push only, full: no write, depth unchanged, o_Overflow <= 1.
  - Pop only, not empty: depth-1 (entry contents unchanged).
  - Pop only, empty: no change, o_Underflow <= 1.
  - Push+pop, not empty: top entry replaced with o_PC; depth unchanged.
  - Push+pop, empty: behaves as push only.
- The push/pop legality rules above apply regardless of i_LD_PC.
- Sticky flags:
  - i_ClrErr clears both flags on the edge.
  - If a new error occurs on the same edge as i_ClrErr, the set wins.
- o_Full, o_Empty and o_Top are combinational from depth and stack contents.

Optional Feature:
- Macro: PC_BRK_EN.
- Defined:
  - Adds ports i_BrkAddr (in, WIDTH), i_BrkEn (in, 1), i_BrkClr (in, 1), o_BrkHit (out, 1, resets to 0).
  - On an edge where i_LD_PC=1, i_BrkEn=1 and the mux output equals i_BrkAddr: the PC loads, and o_BrkHit <= 1 (sticky).
  - While o_BrkHit=1, i_LD_PC, i_Push and i_Pop are ignored (PC and stack frozen).
  - i_BrkClr clears o_BrkHit on the edge; the PC may load on the following edge.
- Not defined: the breakpoint ports do not exist and the PC is never frozen.

Decomposition:
- Package pc_pkg holds:
  - PCMUX encoding localparams: PCMUX_PC1=2'b00, PCMUX_BUS=2'b01, PCMUX_ADDER=2'b10, PCMUX_STACK=2'b11;
  - default WIDTH;
  - default RESET_VEC.
- Sub-module pc_ret_stack (WIDTH, DEPTH):
  - owns entries, depth, full/empty/top, and overflow/underflow;
  - inputs: push, pop, push data, clear-error.
- The top level owns the PC register, next-PC mux and breakpoint logic.

Test Plan:
- Reset with o_PC driven to 16'h1234 beforehand -> o_PC=16'h3000, o_Depth=0, o_Empty=1, all flags 0, immediately on i_Reset rise.
- LD_PC with mux 00 for 3 edges from 16'h3000 -> 16'h3003. With o_PC=16'hFFFF, mux 00 -> 16'h0000.
- o_PC=16'h3005: push + LD_PC with mux 10, i_Addr=16'h4000 -> o_PC=16'h4000, o_Top=16'h3005, o_Depth=1. Next edge: pop + LD_PC with mux 11 -> o_PC=16'h3005, o_Empty=1.
- DEPTH=4: 5 pushes -> o_Full=1, o_Overflow=1, o_Depth=4, top = 4th pushed PC. Then 5 pops -> o_Underflow=1, o_Depth=0. i_ClrErr -> both flags 0.
- o_PC=16'h3010, depth 2, top 16'h3001: push+pop -> depth 2, o_Top=16'h3010.
- PC_BRK_EN, i_BrkAddr=16'h3002, i_BrkEn=1, stepping PC+1 from 16'h3000 -> o_PC=16'h3002, o_BrkHit=1, PC holds for 3 LD edges. i_BrkClr -> next LD gives 16'h3003.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings and defaults for the LC3 program counter and return stack.
package pc_pkg;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;
  localparam logic [1:0] PCMUX_STACK = 2'b11;

  localparam int unsigned DEFAULT_WIDTH     = 16;
  localparam logic [15:0] DEFAULT_RESET_VEC = 16'h3000;

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO of saved return PCs with depth tracking and sticky overflow/underflow flags.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = $clog2(DEPTH + 1)
) (
  input  logic             i_CLK,
  input  logic             i_Reset,
  input  logic             i_Push,
  input  logic             i_Pop,
  input  logic [WIDTH-1:0] i_Data,
  input  logic             i_ClrErr,
  output logic [WIDTH-1:0] o_Top,
  output logic [DW-1:0]    o_Depth,
  output logic             o_Full,
  output logic             o_Empty,
  output logic             o_Overflow,
  output logic             o_Underflow
);

  localparam logic [DW-1:0] One     = DW'(1);
  localparam logic [DW-1:0] DepthMax = DW'(DEPTH);

  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [WIDTH-1:0] entries_d [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic [DW-1:0]    top_idx, wr_idx;
  logic             wr_en, ovf_set, unf_set;
  logic             ovf_q, unf_q;

  assign top_idx = depth_q - One;
  assign o_Depth = depth_q;
  assign o_Full  = (depth_q == DepthMax);
  assign o_Empty = (depth_q == '0);
  assign o_Overflow  = ovf_q;
  assign o_Underflow = unf_q;

  always_comb begin
    o_Top = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!o_Empty && (DW'(i) == top_idx)) o_Top = entries_q[i];
    end
  end

  // Push+pop on a non-empty stack overwrites the top; on an empty stack it is a plain push.
  always_comb begin
    depth_d = depth_q;
    wr_en   = 1'b0;
    wr_idx  = depth_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (i_Push && i_Pop && !o_Empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (i_Push) begin
      if (o_Full) begin
        ovf_set = 1'b1;
      end else begin
        wr_en   = 1'b1;
        depth_d = depth_q + One;
      end
    end else if (i_Pop) begin
      if (o_Empty) unf_set = 1'b1;
      else         depth_d = depth_q - One;
    end
    entries_d = entries_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_en && (DW'(i) == wr_idx)) entries_d[i] = i_Data;
    end
  end

  always_ff @(posedge i_CLK or posedge i_Reset) begin
    if (i_Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      entries_q <= entries_d;
      depth_q   <= depth_d;
      // A new error on the clear edge takes priority.
      ovf_q     <= (ovf_q & ~i_ClrErr) | ovf_set;
      unf_q     <= (unf_q & ~i_ClrErr) | unf_set;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// LC3 program counter with next-PC mux and internal return stack.
// Optional breakpoint/freeze logic is enabled by defining PC_BRK_EN.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEFAULT_RESET_VEC),
  parameter int unsigned      DEPTH     = 4,
  parameter int unsigned      DW        = $clog2(DEPTH + 1)
) (
  input  logic             i_CLK,
  input  logic             i_Reset,
  input  logic             i_LD_PC,
  input  logic [1:0]       i_PCMUX,
  input  logic [WIDTH-1:0] i_Bus,
  input  logic [WIDTH-1:0] i_Addr,
  input  logic             i_Push,
  input  logic             i_Pop,
  input  logic             i_ClrErr,
  output logic [WIDTH-1:0] o_PC,
  output logic [WIDTH-1:0] o_Top,
  output logic [DW-1:0]    o_Depth,
  output logic             o_Full,
  output logic             o_Empty,
  output logic             o_Overflow,
  output logic             o_Underflow
`ifdef PC_BRK_EN
  ,
  input  logic [WIDTH-1:0] i_BrkAddr,
  input  logic             i_BrkEn,
  input  logic             i_BrkClr,
  output logic             o_BrkHit
`endif
);

  logic [WIDTH-1:0] pc_q, pc_mux;
  logic             ld_en, push_en, pop_en;

  assign o_PC = pc_q;

  always_comb begin
    unique case (i_PCMUX)
      PCMUX_PC1:   pc_mux = pc_q + WIDTH'(1);
      PCMUX_BUS:   pc_mux = i_Bus;
      PCMUX_ADDER: pc_mux = i_Addr;
      PCMUX_STACK: pc_mux = o_Top;
    endcase
  end

`ifdef PC_BRK_EN
  logic brk_hit_q;

  // A latched breakpoint freezes PC and stack until cleared.
  assign ld_en    = i_LD_PC & ~brk_hit_q;
  assign push_en  = i_Push & ~brk_hit_q;
  assign pop_en   = i_Pop & ~brk_hit_q;
  assign o_BrkHit = brk_hit_q;

  always_ff @(posedge i_CLK or posedge i_Reset) begin
    if (i_Reset) begin
      brk_hit_q <= 1'b0;
    end else begin
      brk_hit_q <= (brk_hit_q & ~i_BrkClr) | (ld_en & i_BrkEn & (pc_mux == i_BrkAddr));
    end
  end
`else
  assign ld_en   = i_LD_PC;
  assign push_en = i_Push;
  assign pop_en  = i_Pop;
`endif

  always_ff @(posedge i_CLK or posedge i_Reset) begin
    if (i_Reset)    pc_q <= RESET_VEC;
    else if (ld_en) pc_q <= pc_mux;
  end

  pc_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_ret_stack (
    .i_CLK       (i_CLK),
    .i_Reset     (i_Reset),
    .i_Push      (push_en),
    .i_Pop       (pop_en),
    .i_Data      (pc_q),
    .i_ClrErr    (i_ClrErr),
    .o_Top       (o_Top),
    .o_Depth     (o_Depth),
    .o_Full      (o_Full),
    .o_Empty     (o_Empty),
    .o_Overflow  (o_Overflow),
    .o_Underflow (o_Underflow)
  );

endmodule
